// File: rtl/root_select_queue_pkg.sv
// Recoded-float helpers and result type shared by the root selection queue.
package root_select_queue_pkg;
  localparam int internalArgWidth = 33;

  localparam logic [2:0] REC_NAN_CODE  = 3'b111;
  localparam logic [2:0] REC_INF_CODE  = 3'b110;
  localparam logic [2:0] REC_ZERO_CODE = 3'b000;

  typedef struct packed {
    logic                        hit;
    logic [internalArgWidth-1:0] t;
  } RootResult;

  // NaN and Inf share the two top exponent bits set.
  function automatic logic isRecodedSpecial(input logic [2:0] code);
    return (code == REC_NAN_CODE) || (code == REC_INF_CODE);
  endfunction
endpackage

// File: rtl/root_select_queue_recoded_float_lt.sv
// Combinational ordering of two finite recoded floats: a < b and a == b.
module recoded_float_lt
  import root_select_queue_pkg::*;
#(
  parameter int W = internalArgWidth
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq
);
  logic         za, zb, sa, sb;
  logic [W-2:0] ma, mb;

  // Zeros are folded to a canonical +0 so that -0 == +0.
  assign za = (a[W-2 -: 3] == REC_ZERO_CODE);
  assign zb = (b[W-2 -: 3] == REC_ZERO_CODE);
  assign sa = a[W-1] & ~za;
  assign sb = b[W-1] & ~zb;
  assign ma = za ? '0 : a[W-2:0];
  assign mb = zb ? '0 : b[W-2:0];

  assign eq = (sa == sb) && (ma == mb);
  assign lt = (sa != sb) ? sa : (sa ? (ma > mb) : (ma < mb));
endmodule

// File: rtl/root_select_queue.sv
// Picks the nearest valid root above t_min and queues {hit, t} for shading.
module root_select_queue
  import root_select_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = internalArgWidth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               left_root,
  input  logic [W-1:0]               right_root,
  input  logic                       no_real,
  input  logic [W-1:0]               t_min,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       hit,
  output logic [W-1:0]               t_hit,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic      l_lt_min, l_eq_min, r_lt_min, r_eq_min, l_lt_r, l_eq_r;
  logic      cand_l, cand_r, push, pop;
  logic [PW-1:0] wptr, rptr;
  RootResult sel;
  RootResult mem [DEPTH];

  recoded_float_lt #(.W(W)) u_lt_lmin (.a(left_root),  .b(t_min),      .lt(l_lt_min), .eq(l_eq_min));
  recoded_float_lt #(.W(W)) u_lt_rmin (.a(right_root), .b(t_min),      .lt(r_lt_min), .eq(r_eq_min));
  recoded_float_lt #(.W(W)) u_lt_lr   (.a(left_root),  .b(right_root), .lt(l_lt_r),   .eq(l_eq_r));

  assign cand_l = ~no_real & ~isRecodedSpecial(left_root[W-2 -: 3])  & ~l_lt_min & ~l_eq_min;
  assign cand_r = ~no_real & ~isRecodedSpecial(right_root[W-2 -: 3]) & ~r_lt_min & ~r_eq_min;

  always_comb begin
    sel = '0;
    if (cand_l && cand_r) begin
      sel.hit = 1'b1;
      sel.t   = (l_lt_r || l_eq_r) ? left_root : right_root;
    end else if (cand_l) begin
      sel.hit = 1'b1;
      sel.t   = left_root;
    end else if (cand_r) begin
      sel.hit = 1'b1;
      sel.t   = right_root;
    end
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; count gates visibility instead.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= sel;
  end

  assign hit   = out_valid & mem[rptr].hit;
  assign t_hit = out_valid ? mem[rptr].t : '0;
endmodule

// File: tb/tb_root_select_queue.sv
// Self-checking bench: directed table, FIFO corner sequences and random traffic vs a real-valued model.
module tb_root_select_queue;
  import root_select_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int W     = internalArgWidth;

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, no_real, out_valid, out_ready, hit;
  logic [W-1:0]   left_root, right_root, t_min, t_hit;
  logic [2:0]     count;

  root_select_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .left_root(left_root), .right_root(right_root), .no_real(no_real), .t_min(t_min),
    .out_valid(out_valid), .out_ready(out_ready), .hit(hit), .t_hit(t_hit), .count(count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [W:0] mq[$];

  localparam logic [W-1:0] NAN  = {1'b0, 3'b111, 29'd0};
  localparam logic [W-1:0] PINF = {1'b0, 3'b110, 29'd0};
  localparam logic [W-1:0] NINF = {1'b1, 3'b110, 29'd0};
  localparam logic [W-1:0] NEG0 = {1'b1, 32'd0};

  typedef struct packed {
    logic [W-1:0] l, r, tm;
    logic         nr;
    logic         e_hit;
    logic [W-1:0] e_t;
  } vec_t;

  vec_t tbl[12];
  logic [W-1:0] pool[14];

  function automatic logic [W-1:0] f2r(input real v);
    logic [63:0] b;
    int e;
    b = $realtobits(v);
    if (v == 0.0) return {b[63], 32'd0};
    e = int'(b[62:52]) - 1023;
    return {b[63], 9'(e + 256), b[51:29]};
  endfunction

  function automatic bit is_nan(input logic [W-1:0] x); return x[31:29] == 3'b111; endfunction
  function automatic bit is_inf(input logic [W-1:0] x); return x[31:29] == 3'b110; endfunction

  function automatic real r2real(input logic [W-1:0] x);
    real m;
    if (x[31:29] == 3'b000) return 0.0;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(int'(x[31:23])) - 256.0));
    return x[32] ? -m : m;
  endfunction

  // Reference selection on decoded real values.
  function automatic logic [W:0] ref_sel(input logic [W-1:0] l, r, tm, input logic nr);
    real lv, rv, tv;
    bit cl, cr;
    lv = r2real(l); rv = r2real(r); tv = r2real(tm);
    cl = !nr && !is_nan(l) && !is_inf(l) && (lv > tv);
    cr = !nr && !is_nan(r) && !is_inf(r) && (rv > tv);
    if (cl && cr) return (rv < lv) ? {1'b1, r} : {1'b1, l};
    if (cl) return {1'b1, l};
    if (cr) return {1'b1, r};
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_out();
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    if (mq.size() != 0) chk("head", 64'({hit, t_hit}), 64'(mq[0]));
    else                chk("idle_out", 64'({hit, t_hit}), 64'd0);
  endtask

  // Called at a negedge: check, drive, advance model, then move to the next negedge.
  task automatic step(input logic iv, input logic [W-1:0] l, r, tm, input logic nr, input logic ordy);
    logic [W:0] s;
    bit pop, push;
    check_out();
    in_valid = iv; left_root = l; right_root = r; t_min = tm; no_real = nr; out_ready = ordy;
    s    = ref_sel(l, r, tm, nr);
    pop  = (mq.size() != 0) && ordy;
    push = iv && (mq.size() < DEPTH);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, 1'b0, ordy);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; no_real = 1'b0;
    left_root = '0; right_root = '0; t_min = '0;

    tbl[0]  = '{f2r(2.0),  f2r(5.0),  f2r(0.0),  1'b0, 1'b1, f2r(2.0)};
    tbl[1]  = '{f2r(-3.0), f2r(4.0),  f2r(0.0),  1'b0, 1'b1, f2r(4.0)};
    tbl[2]  = '{f2r(-1.0), f2r(-2.0), f2r(0.0),  1'b0, 1'b0, '0};
    tbl[3]  = '{f2r(0.0),  f2r(0.0),  f2r(0.0),  1'b0, 1'b0, '0};
    tbl[4]  = '{f2r(1.0),  f2r(1.0),  f2r(0.0),  1'b1, 1'b0, '0};
    tbl[5]  = '{NAN,       f2r(3.0),  f2r(0.0),  1'b0, 1'b1, f2r(3.0)};
    tbl[6]  = '{PINF,      f2r(7.0),  f2r(0.0),  1'b0, 1'b1, f2r(7.0)};
    tbl[7]  = '{f2r(5.0),  f2r(5.0),  f2r(0.0),  1'b0, 1'b1, f2r(5.0)};
    tbl[8]  = '{NEG0,      f2r(0.0),  f2r(-1.0), 1'b0, 1'b1, NEG0};
    tbl[9]  = '{f2r(3.0),  f2r(1.5),  f2r(1.5),  1'b0, 1'b1, f2r(3.0)};
    tbl[10] = '{f2r(-2.0), f2r(-4.0), f2r(-5.0), 1'b0, 1'b1, f2r(-4.0)};
    tbl[11] = '{f2r(0.5),  f2r(0.25), f2r(0.3),  1'b0, 1'b1, f2r(0.5)};

    pool[0] = f2r(0.0);   pool[1] = f2r(0.5);  pool[2] = f2r(1.0);   pool[3] = f2r(-1.0);
    pool[4] = f2r(2.0);   pool[5] = f2r(3.25); pool[6] = f2r(-7.5);  pool[7] = f2r(100.0);
    pool[8] = f2r(-0.125); pool[9] = f2r(5.0); pool[10] = NEG0;      pool[11] = NAN;
    pool[12] = PINF;      pool[13] = NINF;

    @(posedge clk);
    @(negedge clk);
    check_out();
    reset = 1'b0;

    // Directed table: each vector is pushed into an empty queue and inspected the next cycle.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].l, tbl[i].r, tbl[i].tm, tbl[i].nr, 1'b1);
      chk($sformatf("tbl%0d_hit", i), 64'(hit), 64'(tbl[i].e_hit));
      chk($sformatf("tbl%0d_t", i), 64'(t_hit), 64'(tbl[i].e_t));
    end
    idle(1'b1);
    chk("drained_count", 64'(count), 64'd0);

    // Back-pressure: five pushes with no consumer, then drain.
    for (int i = 0; i < 5; i++)
      step(1'b1, f2r(real'(i + 1)), f2r(50.0), f2r(0.0), 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Steady occupancy of two with push and pop every cycle; pointers wrap.
    step(1'b1, f2r(10.0), f2r(20.0), f2r(0.0), 1'b0, 1'b0);
    step(1'b1, f2r(11.0), f2r(20.0), f2r(0.0), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, f2r(real'(12 + i)), f2r(-1.0), f2r(0.0), 1'b0, 1'b1);
    chk("steady_count", 64'(count), 64'd2);
    idle(1'b1); idle(1'b1);

    // Reset with three entries queued and a handshake on the reset edge.
    for (int i = 0; i < 3; i++)
      step(1'b1, f2r(real'(30 + i)), f2r(60.0), f2r(0.0), 1'b0, 1'b0);
    check_out();
    in_valid = 1'b1; left_root = f2r(77.0); right_root = f2r(78.0); out_ready = 1'b1; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    idle(1'b1);
    step(1'b1, f2r(0.5), f2r(-0.5), f2r(0.0), 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3, 0) != 0), pool[$urandom_range(13, 0)], pool[$urandom_range(13, 0)],
           pool[$urandom_range(10, 0)], ($urandom_range(7, 0) == 0), ($urandom_range(1, 0) == 1));
    end
    for (int i = 0; i < 5; i++) idle(1'b1);
    check_out();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
